// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   state_e      exception FSM encodings (ST_RUN / ST_EXC_WAIT / ST_IF_DRAIN)
//   SRC_*        stall-source indices, oldest stage first (index 0 = MEM2)
//   prefix_or    per-index "this source or any older source stalls"
//   oldest_only  one-hot of the oldest asserted stall source (bubble point)
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_EXC_WAIT = 2'd1,
    ST_IF_DRAIN = 2'd2
  } state_e;

  localparam int N_SRC  = 4;
  localparam int SRC_M2 = 0;  // dcache_stall
  localparam int SRC_EX = 1;  // divide occupancy
  localparam int SRC_ID = 2;  // load-use hazard
  localparam int SRC_IF = 3;  // icache_stall

  // Bit i set when source i or any older source (lower index) is stalling.
  function automatic logic [N_SRC-1:0] prefix_or(input logic [N_SRC-1:0] v);
    logic [N_SRC-1:0] r;
    r[0] = v[0];
    for (int i = 1; i < N_SRC; i++) begin
      r[i] = r[i-1] | v[i];
    end
    return r;
  endfunction

  // Keep only the oldest asserted source; younger stalls are covered by its hold.
  function automatic logic [N_SRC-1:0] oldest_only(input logic [N_SRC-1:0] v);
    return v & ~(prefix_or(v) << 1);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_div_occupancy_cnt.sv
// Divide occupancy counter: tracks how many EX cycles a divide still owns.
// Latency: busy rises the cycle after an accepted start.
// Backpressure: start ignored while busy; clr wins over load and decrement.
//
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-low reset
//   start  in  divide issued in EX this cycle
//   clr    in  force counter to zero (exception commit)
//   busy   out counter non-zero
module div_occupancy_cnt #(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clr,
  output logic busy
);
  import pipe_stall_ctrl_pkg::*;

  localparam int CW = $clog2(DIV_CYCLES);
  // The issue cycle itself counts as the first divide cycle.
  localparam logic [CW-1:0] LOAD_VAL = CW'(DIV_CYCLES - 1);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else if (start) begin
      cnt_d = LOAD_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer driving wr/flush pins of the 7 PF..WB registers.
// Latency: zero; outputs are combinational from inputs plus registered state.
// Backpressure: stalls drop write enables oldest-first and bubble the register below.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   icache_stall, dcache_stall    cache stalls (IF, MEM2)
//   ld_use                        load-use hazard in ID
//   div_start                     divide issued in EX (ignored while div_busy)
//   ex_mispredict                 branch resolved wrong in EX
//   exc_req                       MEM1 exception or eret
//   *_wr / *_flush                per-register write enables and flushes
//   exc_commit                    pulse: PC redirected to exception vector
//   div_busy                      divide still occupying EX
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic icache_stall,
  input  logic dcache_stall,
  input  logic ld_use,
  input  logic div_start,
  input  logic ex_mispredict,
  input  logic exc_req,
  output logic pc_wr,
  output logic pf_if_wr,
  output logic if_id_wr,
  output logic id_ex_wr,
  output logic ex_mem1_wr,
  output logic mem1_mem2_wr,
  output logic mem2_wb_wr,
  output logic pf_if_flush,
  output logic if_id_flush,
  output logic id_ex_flush,
  output logic ex_mem1_flush,
  output logic mem1_mem2_flush,
  output logic mem2_wb_flush,
  output logic exc_commit,
  output logic div_busy
);
  import pipe_stall_ctrl_pkg::*;

  state_e           state_q, state_d;
  logic             mis_pend_q, mis_pend_d;
  logic             div_busy_raw;
  logic             commit;
  logic [N_SRC-1:0] stall_src, hold, bubble;

  // Commit never occurs mid-dcache-stall: MEM1/MEM2 must be able to move.
  assign commit = !dcache_stall &&
                  ((state_q == ST_RUN && exc_req) || state_q == ST_EXC_WAIT);

  div_occupancy_cnt #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .clr   (commit),
    .busy  (div_busy_raw)
  );

  always_comb begin
    stall_src         = '0;
    stall_src[SRC_M2] = dcache_stall;
    stall_src[SRC_EX] = div_busy_raw;
    stall_src[SRC_ID] = ld_use;
    stall_src[SRC_IF] = icache_stall;
    hold   = prefix_or(stall_src);
    bubble = oldest_only(stall_src);

    // Baseline: a register holds when its producer or anything older stalls.
    // MEM1 has no stall source, so it follows MEM2; PF follows IF.
    pc_wr           = !hold[SRC_IF];
    pf_if_wr        = !hold[SRC_IF];
    if_id_wr        = !hold[SRC_IF];
    id_ex_wr        = !hold[SRC_ID];
    ex_mem1_wr      = !hold[SRC_EX];
    mem1_mem2_wr    = !hold[SRC_M2];
    mem2_wb_wr      = !hold[SRC_M2];
    pf_if_flush     = 1'b0;
    if_id_flush     = bubble[SRC_IF];
    id_ex_flush     = bubble[SRC_ID];
    ex_mem1_flush   = bubble[SRC_EX];
    mem1_mem2_flush = 1'b0;
    mem2_wb_flush   = bubble[SRC_M2];
    exc_commit      = 1'b0;
    div_busy        = div_busy_raw;
    state_d         = state_q;
    mis_pend_d      = mis_pend_q;

    if (commit) begin
      // Everything younger than MEM2 is squashed; MEM2 retires into WB.
      // Any mispredict this cycle or pending is moot after the redirect.
      exc_commit      = 1'b1;
      pc_wr           = 1'b1;
      pf_if_wr        = 1'b0;
      if_id_wr        = 1'b0;
      id_ex_wr        = 1'b0;
      ex_mem1_wr      = 1'b0;
      mem1_mem2_wr    = 1'b0;
      mem2_wb_wr      = 1'b1;
      pf_if_flush     = 1'b1;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
      ex_mem1_flush   = 1'b1;
      mem1_mem2_flush = 1'b1;
      mem2_wb_flush   = 1'b0;
      mis_pend_d      = 1'b0;
      state_d         = icache_stall ? ST_IF_DRAIN : ST_RUN;
    end else begin
      // The branch's delay slot is in ID; wrong-path work is only in PF/IF.
      // It can be squashed only when the delay slot advances into EX.
      if ((ex_mispredict || mis_pend_q) && id_ex_wr) begin
        pf_if_wr    = 1'b0;
        if_id_wr    = 1'b0;
        pf_if_flush = 1'b1;
        if_id_flush = 1'b1;
        mis_pend_d  = 1'b0;
      end else if (ex_mispredict) begin
        mis_pend_d  = 1'b1;
      end

      case (state_q)
        ST_RUN: begin
          if (exc_req) begin
            state_d = ST_EXC_WAIT;
          end
        end
        ST_EXC_WAIT: begin
          state_d = ST_EXC_WAIT;
        end
        ST_IF_DRAIN: begin
          // The fetch launched before the redirect returns a stale word:
          // keep PF frozen and bubble IF/ID until it arrives, plus one cycle.
          pc_wr       = 1'b0;
          pf_if_wr    = 1'b0;
          if_id_wr    = 1'b0;
          if_id_flush = 1'b1;
          if (!icache_stall) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end

    if (!rst) begin
      pc_wr           = 1'b0;
      pf_if_wr        = 1'b0;
      if_id_wr        = 1'b0;
      id_ex_wr        = 1'b0;
      ex_mem1_wr      = 1'b0;
      mem1_mem2_wr    = 1'b0;
      mem2_wb_wr      = 1'b0;
      pf_if_flush     = 1'b0;
      if_id_flush     = 1'b0;
      id_ex_flush     = 1'b0;
      ex_mem1_flush   = 1'b0;
      mem1_mem2_flush = 1'b0;
      mem2_wb_flush   = 1'b0;
      exc_commit      = 1'b0;
      div_busy        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      mis_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mis_pend_q <= mis_pend_d;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl (DIV_CYCLES=4): cycle vectors with hand-derived
// expected outputs, pushed to a scoreboard when driven and compared at negedge.
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic icache_stall = 1'b0, dcache_stall = 1'b0, ld_use = 1'b0;
  logic div_start = 1'b0, ex_mispredict = 1'b0, exc_req = 1'b0;
  logic pc_wr, pf_if_wr, if_id_wr, id_ex_wr, ex_mem1_wr, mem1_mem2_wr, mem2_wb_wr;
  logic pf_if_flush, if_id_flush, id_ex_flush, ex_mem1_flush, mem1_mem2_flush, mem2_wb_flush;
  logic exc_commit, div_busy;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall), .ld_use(ld_use),
    .div_start(div_start), .ex_mispredict(ex_mispredict), .exc_req(exc_req),
    .pc_wr(pc_wr), .pf_if_wr(pf_if_wr), .if_id_wr(if_id_wr), .id_ex_wr(id_ex_wr),
    .ex_mem1_wr(ex_mem1_wr), .mem1_mem2_wr(mem1_mem2_wr), .mem2_wb_wr(mem2_wb_wr),
    .pf_if_flush(pf_if_flush), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem1_flush(ex_mem1_flush), .mem1_mem2_flush(mem1_mem2_flush),
    .mem2_wb_flush(mem2_wb_flush), .exc_commit(exc_commit), .div_busy(div_busy)
  );

  // Input bits: {rst, icache_stall, dcache_stall, ld_use, div_start, ex_mispredict, exc_req}
  localparam logic [6:0] RST0 = 7'b0000000;
  localparam logic [6:0] IDLE = 7'b1000000;
  localparam logic [6:0] IC   = 7'b0100000;
  localparam logic [6:0] DC   = 7'b0010000;
  localparam logic [6:0] LU   = 7'b0001000;
  localparam logic [6:0] DS   = 7'b0000100;
  localparam logic [6:0] MP   = 7'b0000010;
  localparam logic [6:0] ER   = 7'b0000001;
  // wr bits: {pc, pf_if, if_id, id_ex, ex_mem1, mem1_mem2, mem2_wb}
  // fl bits: {pf_if, if_id, id_ex, ex_mem1, mem1_mem2, mem2_wb}
  localparam logic [6:0] W_ALL = 7'b1111111;
  localparam logic [6:0] W_NON = 7'b0000000;
  localparam logic [6:0] W_ID  = 7'b0000111;  // ld_use hold
  localparam logic [6:0] W_IF  = 7'b0001111;  // IF hold / drain
  localparam logic [6:0] W_EX  = 7'b0000011;  // divide hold
  localparam logic [6:0] W_EXC = 7'b1000001;  // commit
  localparam logic [6:0] W_MIS = 7'b1001111;  // mispredict flush
  localparam logic [5:0] F_NON = 6'b000000;
  localparam logic [5:0] F_IF  = 6'b010000;
  localparam logic [5:0] F_ID  = 6'b001000;
  localparam logic [5:0] F_EX  = 6'b000100;
  localparam logic [5:0] F_M2  = 6'b000001;
  localparam logic [5:0] F_EXC = 6'b111110;
  localparam logic [5:0] F_MIS = 6'b110000;

  typedef struct packed {
    logic [6:0] in;
    logic [6:0] wr;
    logic [5:0] fl;
    logic       ec;
    logic       db;
  } vec_t;

  typedef struct {
    logic [14:0] exp;
    int          id;
  } sb_t;

  localparam int NVEC = 45;
  vec_t tbl [NVEC];
  sb_t  sb [$];
  int   n_run  = 0;
  int   n_fail = 0;
  logic [14:0] act;

  assign act = {pc_wr, pf_if_wr, if_id_wr, id_ex_wr, ex_mem1_wr, mem1_mem2_wr, mem2_wb_wr,
                pf_if_flush, if_id_flush, id_ex_flush, ex_mem1_flush, mem1_mem2_flush,
                mem2_wb_flush, exc_commit, div_busy};

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      n_run++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL vec%0d: got wr=%b fl=%b ec=%b db=%b, want wr=%b fl=%b ec=%b db=%b",
                 e.id, act[14:8], act[7:2], act[1], act[0],
                 e.exp[14:8], e.exp[7:2], e.exp[1], e.exp[0]);
      end
    end
  end

  task automatic step(input logic [6:0] in, input logic [14:0] exp, input int id);
    sb_t e;
    @(posedge clk);
    #1;
    {rst, icache_stall, dcache_stall, ld_use, div_start, ex_mispredict, exc_req} = in;
    e.exp = exp;
    e.id  = id;
    sb.push_back(e);
  endtask

  initial begin
    // reset: outputs forced low regardless of inputs
    tbl[0]  = {RST0,           W_NON, F_NON, 1'b0, 1'b0};
    tbl[1]  = {IC|DC|ER,       W_NON, F_NON, 1'b0, 1'b0};
    tbl[2]  = {IDLE,           W_ALL, F_NON, 1'b0, 1'b0};
    // load-use bubble, single stalls, oldest-source bubble
    tbl[3]  = {IDLE|LU,        W_ID,  F_ID,  1'b0, 1'b0};
    tbl[4]  = {IDLE,           W_ALL, F_NON, 1'b0, 1'b0};
    tbl[5]  = {IDLE|IC,        W_IF,  F_IF,  1'b0, 1'b0};
    tbl[6]  = {IDLE|DC,        W_NON, F_M2,  1'b0, 1'b0};
    tbl[7]  = {IDLE|DC|LU|IC,  W_NON, F_M2,  1'b0, 1'b0};
    tbl[8]  = {IDLE|LU|IC,     W_ID,  F_ID,  1'b0, 1'b0};
    // divide: busy 3 cycles, restart while busy ignored
    tbl[9]  = {IDLE|DS,        W_ALL, F_NON, 1'b0, 1'b0};
    tbl[10] = {IDLE|DS,        W_EX,  F_EX,  1'b0, 1'b1};
    tbl[11] = {IDLE,           W_EX,  F_EX,  1'b0, 1'b1};
    tbl[12] = {IDLE,           W_EX,  F_EX,  1'b0, 1'b1};
    tbl[13] = {IDLE,           W_ALL, F_NON, 1'b0, 1'b0};
    // divide keeps counting through other stalls
    tbl[14] = {IDLE|DS,        W_ALL, F_NON, 1'b0, 1'b0};
    tbl[15] = {IDLE|LU,        W_EX,  F_EX,  1'b0, 1'b1};
    tbl[16] = {IDLE|DC,        W_NON, F_M2,  1'b0, 1'b1};
    tbl[17] = {IDLE,           W_EX,  F_EX,  1'b0, 1'b1};
    tbl[18] = {IDLE,           W_ALL, F_NON, 1'b0, 1'b0};
    // exception held by dcache stall, then commit
    tbl[19] = {IDLE|ER|DC,     W_NON, F_M2,  1'b0, 1'b0};
    tbl[20] = {IDLE|DC,        W_NON, F_M2,  1'b0, 1'b0};
    tbl[21] = {IDLE|DC|ER,     W_NON, F_M2,  1'b0, 1'b0};
    tbl[22] = {IDLE,           W_EXC, F_EXC, 1'b1, 1'b0};
    tbl[23] = {IDLE,           W_ALL, F_NON, 1'b0, 1'b0};
    // exception during icache stall -> IF_DRAIN
    tbl[24] = {IDLE|ER|IC,     W_EXC, F_EXC, 1'b1, 1'b0};
    tbl[25] = {IDLE|IC,        W_IF,  F_IF,  1'b0, 1'b0};
    tbl[26] = {IDLE|IC|ER,     W_IF,  F_IF,  1'b0, 1'b0};
    tbl[27] = {IDLE,           W_IF,  F_IF,  1'b0, 1'b0};
    tbl[28] = {IDLE,           W_ALL, F_NON, 1'b0, 1'b0};
    // mispredict pending across ld_use, immediate, and with icache stall
    tbl[29] = {IDLE|LU|MP,     W_ID,  F_ID,  1'b0, 1'b0};
    tbl[30] = {IDLE|LU,        W_ID,  F_ID,  1'b0, 1'b0};
    tbl[31] = {IDLE,           W_MIS, F_MIS, 1'b0, 1'b0};
    tbl[32] = {IDLE,           W_ALL, F_NON, 1'b0, 1'b0};
    tbl[33] = {IDLE|MP,        W_MIS, F_MIS, 1'b0, 1'b0};
    tbl[34] = {IDLE,           W_ALL, F_NON, 1'b0, 1'b0};
    tbl[35] = {IDLE|IC|MP,     W_IF,  F_MIS, 1'b0, 1'b0};
    tbl[36] = {IDLE,           W_ALL, F_NON, 1'b0, 1'b0};
    // commit beats mispredict and clears pending / divide
    tbl[37] = {IDLE|ER|MP,     W_EXC, F_EXC, 1'b1, 1'b0};
    tbl[38] = {IDLE,           W_ALL, F_NON, 1'b0, 1'b0};
    tbl[39] = {IDLE|LU|MP,     W_ID,  F_ID,  1'b0, 1'b0};
    tbl[40] = {IDLE|ER,        W_EXC, F_EXC, 1'b1, 1'b0};
    tbl[41] = {IDLE,           W_ALL, F_NON, 1'b0, 1'b0};
    tbl[42] = {IDLE|DS,        W_ALL, F_NON, 1'b0, 1'b0};
    tbl[43] = {IDLE|ER,        W_EXC, F_EXC, 1'b1, 1'b1};
    tbl[44] = {IDLE,           W_ALL, F_NON, 1'b0, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].in, {tbl[i].wr, tbl[i].fl, tbl[i].ec, tbl[i].db}, i);
    end

    // reset in the middle of IF_DRAIN returns to RUN
    step(IDLE|ER|IC, {W_EXC, F_EXC, 1'b1, 1'b0}, 100);
    step(IDLE|IC,    {W_IF,  F_IF,  1'b0, 1'b0}, 101);
    step(RST0|IC,    {W_NON, F_NON, 1'b0, 1'b0}, 102);
    step(IDLE,       {W_ALL, F_NON, 1'b0, 1'b0}, 103);
    // reset clears a running divide
    step(IDLE|DS,    {W_ALL, F_NON, 1'b0, 1'b0}, 104);
    step(RST0,       {W_NON, F_NON, 1'b0, 1'b0}, 105);
    step(IDLE,       {W_ALL, F_NON, 1'b0, 1'b0}, 106);
    // reset clears a pending mispredict
    step(IDLE|LU|MP, {W_ID,  F_ID,  1'b0, 1'b0}, 107);
    step(RST0,       {W_NON, F_NON, 1'b0, 1'b0}, 108);
    step(IDLE,       {W_ALL, F_NON, 1'b0, 1'b0}, 109);

    @(negedge clk);
    #1;
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
